// File: rtl/oflow_score_board_pkg.sv
// Shared types and constants for the oflow registration score board.
// Frame/set widths normally come from the core defines; fallbacks keep the block standalone.
`ifndef SET_LEN
`define SET_LEN 8
`endif
`ifndef TOTAL_FRAME_NUM_WIDTH
`define TOTAL_FRAME_NUM_WIDTH 16
`endif

package oflow_score_board_pkg;

  typedef enum logic [1:0] {
    idle_st,
    accum_st,
    result_st
  } state_t;

  // Wide enough for any score width in use; users slice the low SCORE_WIDTH bits.
  localparam int          SCORE_WIDTH_MAX = 64;
  localparam logic [63:0] SCORE_MAX       = '1;

endpackage

// File: rtl/oflow_score_min_tree.sv
// Combinational comparator tree: minimum score among valid lanes, lower lane wins ties.
module oflow_score_min_tree #(
  parameter int PE_NUM      = 8,
  parameter int SCORE_WIDTH = 16,
  parameter int ID_WIDTH    = 12
) (
  input  logic [PE_NUM*SCORE_WIDTH-1:0] scores,
  input  logic [PE_NUM*ID_WIDTH-1:0]    ids,
  input  logic [PE_NUM-1:0]             lane_valid,
  output logic [SCORE_WIDTH-1:0]        min_score,
  output logic [ID_WIDTH-1:0]           min_id,
  output logic                          any_valid
);

  // Heap-ordered tree padded to a power of two; node n has children 2n+1 and 2n+2,
  // so the left child always covers the lower lane indices.
  localparam int P2    = (PE_NUM <= 1) ? 1 : (1 << $clog2(PE_NUM));
  localparam int NODES = 2 * P2 - 1;

  logic [SCORE_WIDTH-1:0] n_score [NODES];
  logic [ID_WIDTH-1:0]    n_id    [NODES];
  logic                   n_valid [NODES];

  for (genvar k = 0; k < P2; k++) begin : g_leaf
    if (k < PE_NUM) begin : g_lane
      assign n_score[P2-1+k] = scores[k*SCORE_WIDTH +: SCORE_WIDTH];
      assign n_id[P2-1+k]    = ids[k*ID_WIDTH +: ID_WIDTH];
      assign n_valid[P2-1+k] = lane_valid[k];
    end else begin : g_pad
      assign n_score[P2-1+k] = '1;
      assign n_id[P2-1+k]    = '0;
      assign n_valid[P2-1+k] = 1'b0;
    end
  end

  for (genvar n = 0; n < P2 - 1; n++) begin : g_node
    logic take_l;
    assign take_l     = n_valid[2*n+1] &&
                        (!n_valid[2*n+2] || (n_score[2*n+1] <= n_score[2*n+2]));
    assign n_score[n] = take_l ? n_score[2*n+1] : n_score[2*n+2];
    assign n_id[n]    = take_l ? n_id[2*n+1]    : n_id[2*n+2];
    assign n_valid[n] = n_valid[2*n+1] | n_valid[2*n+2];
  end

  assign min_score = n_score[0];
  assign min_id    = n_id[0];
  assign any_valid = n_valid[0];

endmodule

// File: rtl/oflow_score_board.sv
// Collects per-set score vectors, keeps a running best over the registration
// and issues one match decision per current-frame object.
`ifndef SET_LEN
`define SET_LEN 8
`endif
`ifndef TOTAL_FRAME_NUM_WIDTH
`define TOTAL_FRAME_NUM_WIDTH 16
`endif

module oflow_score_board
  import oflow_score_board_pkg::*;
#(
  parameter int PE_NUM      = 8,
  parameter int SCORE_WIDTH = 16,
  parameter int ID_WIDTH    = 12
) (
  input  logic                              clk,
  input  logic                              reset_N,
  input  logic                              start_registration,
  input  logic [`TOTAL_FRAME_NUM_WIDTH-1:0] frame_num,
  input  logic [`SET_LEN-1:0]               num_of_sets,
  input  logic [`SET_LEN-1:0]               counter_of_sets,
  input  logic                              done_score_calc,
  input  logic [PE_NUM*SCORE_WIDTH-1:0]     scores,
  input  logic [PE_NUM*ID_WIDTH-1:0]        ids,
  input  logic [PE_NUM-1:0]                 lane_valid,
  input  logic [SCORE_WIDTH-1:0]            score_threshold,
  output logic                              done_registration,
  output logic [ID_WIDTH-1:0]               best_id,
  output logic [SCORE_WIDTH-1:0]            best_score,
  output logic                              matched,
  output logic                              err_unexpected
);

  localparam logic [SCORE_WIDTH-1:0] SCORE_ONES = SCORE_MAX[SCORE_WIDTH-1:0];

  state_t state, state_nxt;

  logic [SCORE_WIDTH-1:0] set_min_score;
  logic [ID_WIDTH-1:0]    set_min_id;
  logic                   set_any_valid;

  logic [SCORE_WIDTH-1:0] run_score;
  logic [ID_WIDTH-1:0]    run_id;
  logic                   seen;

  logic [SCORE_WIDTH-1:0] best_score_q;
  logic [ID_WIDTH-1:0]    best_id_q;
  logic                   matched_q;
  logic                   err_q;

  logic clear_run, acc_en, load_out, err_d, matched_now;

  oflow_score_min_tree #(
    .PE_NUM      (PE_NUM),
    .SCORE_WIDTH (SCORE_WIDTH),
    .ID_WIDTH    (ID_WIDTH)
  ) u_min_tree (
    .scores     (scores),
    .ids        (ids),
    .lane_valid (lane_valid),
    .min_score  (set_min_score),
    .min_id     (set_min_id),
    .any_valid  (set_any_valid)
  );

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) state <= idle_st;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    clear_run = 1'b0;
    acc_en    = 1'b0;
    load_out  = 1'b0;
    err_d     = 1'b0;
    unique case (state)
      idle_st: begin
        err_d = done_score_calc;
        if (start_registration) begin
          clear_run = 1'b1;
          state_nxt = (frame_num != '0) ? accum_st : result_st;
        end
      end
      accum_st: begin
        // A restart aborts the object in flight; it outranks a coincident set.
        if (start_registration) begin
          clear_run = 1'b1;
        end else if (done_score_calc) begin
          acc_en = 1'b1;
          if (counter_of_sets == num_of_sets) state_nxt = result_st;
        end
      end
      result_st: begin
        load_out = 1'b1;
        err_d    = done_score_calc;
        if (start_registration) begin
          clear_run = 1'b1;
          state_nxt = (frame_num != '0) ? accum_st : result_st;
        end else begin
          state_nxt = idle_st;
        end
      end
      default: state_nxt = idle_st;
    endcase
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      run_score <= SCORE_ONES;
      run_id    <= '0;
      seen      <= 1'b0;
    end else if (clear_run) begin
      run_score <= SCORE_ONES;
      run_id    <= '0;
      seen      <= 1'b0;
    end else if (acc_en) begin
      if (set_any_valid && (set_min_score < run_score)) begin
        run_score <= set_min_score;
        run_id    <= set_min_id;
      end
      if (set_any_valid) seen <= 1'b1;
    end
  end

  assign matched_now = seen && (run_score <= score_threshold);

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      best_score_q <= SCORE_ONES;
      best_id_q    <= '0;
      matched_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      err_q <= err_d;
      if (load_out) begin
        best_score_q <= run_score;
        best_id_q    <= run_id;
        matched_q    <= matched_now;
      end
    end
  end

  // Result is visible in the RESULT cycle itself, then held from the registers.
  assign done_registration = (state == result_st);
  assign best_score        = load_out ? run_score   : best_score_q;
  assign best_id           = load_out ? run_id      : best_id_q;
  assign matched           = load_out ? matched_now : matched_q;
  assign err_unexpected    = err_q;

endmodule
